// File: rtl/count_event_fifo.sv
// count_event_fifo: watches an upstream counter, turns overflow rising edges
// and upward threshold crossings into timestamped records, and queues them
// in a small FIFO with valid/ready pop and a saturating drop counter.
// DEPTH must be a power of two and at least 2.
module count_event_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         count,
  input  logic                     overflow,
  input  logic [WIDTH-1:0]         thresh,
  input  logic                     thresh_en,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [1:0]               evt_type,
  output logic [TS_W-1:0]          evt_ts,
  output logic [WIDTH-1:0]         evt_count,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]       etype;
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] cnt;
  } rec_t;

  // Timestamp and previous-sample history
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              prev_ovf_q, prev_ovf_d;
  logic [WIDTH-1:0]  prev_cnt_q, prev_cnt_d;
  logic              prev_vld_q, prev_vld_d;

  // FIFO bookkeeping; head_q is a registered copy of the oldest entry
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              head_vld_q, head_vld_d;
  rec_t              head_q, head_d;
  rec_t              mem_q [DEPTH];

  // Per-cycle decode
  logic              ovf_evt;
  logic              thr_evt;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              full;
  rec_t              push_rec;

  // Event detection, FIFO next-state and head selection
  always_comb begin
    ts_d       = ts_q;
    prev_ovf_d = prev_ovf_q;
    prev_cnt_d = prev_cnt_q;
    prev_vld_d = prev_vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_d     = drop_q;
    head_vld_d = head_vld_q;
    head_d     = head_q;
    ovf_evt    = 1'b0;
    thr_evt    = 1'b0;
    push_req   = 1'b0;
    push_ok    = 1'b0;
    pop        = 1'b0;
    full       = 1'b0;
    push_rec   = '0;

    // Overflow is edge-detected; threshold needs a valid previous sample and
    // an upward crossing, so a downward wrap never fires on its own.
    ovf_evt  = overflow & ~prev_ovf_q;
    thr_evt  = thresh_en & prev_vld_q & (prev_cnt_q < thresh) & (count >= thresh);
    push_req = rst_n & (ovf_evt | thr_evt);

    push_rec.etype = {thr_evt, ovf_evt};
    push_rec.ts    = ts_q;
    push_rec.cnt   = count;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
    pop     = head_vld_q & evt_ready;
    full    = (level_q == LVL_W'(DEPTH));
    push_ok = push_req & (~full | pop);

    if (push_req && full && !pop && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);

    // New head comes from storage, or straight from the incoming record when
    // it lands in the slot the read pointer moves onto.
    if (level_d == '0) begin
      head_vld_d = 1'b0;
      head_d     = '0;
    end else begin
      head_vld_d = 1'b1;
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_rec;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end

    ts_d       = ts_q + TS_W'(1);
    prev_ovf_d = overflow;
    prev_cnt_d = count;
    prev_vld_d = 1'b1;
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q       <= '0;
      prev_ovf_q <= 1'b0;
      prev_cnt_q <= '0;
      prev_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_q     <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      prev_ovf_q <= prev_ovf_d;
      prev_cnt_q <= prev_cnt_d;
      prev_vld_q <= prev_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_q     <= drop_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
    end
  end

  // Record storage; contents are left alone by reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_rec;
    end
  end

  assign evt_valid = head_vld_q;
  assign evt_type  = head_q.etype;
  assign evt_ts    = head_q.ts;
  assign evt_count = head_q.cnt;
  assign level     = level_q;
  assign drop_cnt  = drop_q;

endmodule

// File: doc/count_event_fifo.md
COUNT_EVENT_FIFO -- requirements
Module: count_event_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the width of the observed count.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the event FIFO entries; it must be a power of 2 and at least 2.
REQ-003 The block SHALL have parameter TS_W, default 16, meaning the timestamp width.
REQ-004 The block SHALL have parameter DROP_W, default 8, meaning the dropped-event counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port count, input, WIDTH bits: the upstream counter value.
REQ-008 The block SHALL have port overflow, input, 1 bit: the upstream overflow flag.
REQ-009 The block SHALL have port thresh, input, WIDTH bits: the threshold compare value.
REQ-010 The block SHALL have port thresh_en, input, 1 bit: enables threshold-crossing detection.
REQ-011 The block SHALL have port evt_valid, output, 1 bit: the FIFO head is valid.
REQ-012 The block SHALL have port evt_ready, input, 1 bit: the consumer accepts the head.
REQ-013 The block SHALL have port evt_type, output, 2 bits: 01 overflow, 10 threshold, 11 both.
REQ-014 The block SHALL have port evt_ts, output, TS_W bits: the timestamp of the event.
REQ-015 The block SHALL have port evt_count, output, WIDTH bits: the count sampled at the event.
REQ-016 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: the FIFO occupancy.
REQ-017 The block SHALL have port drop_cnt, output, DROP_W bits: the number of events lost to a full FIFO.

Function
REQ-018 The block SHALL sample all inputs at every rising clk edge; it SHALL hold registered copies prev_ovf, prev_cnt and a prev_vld flag.
REQ-019 The block SHALL detect an overflow event as overflow==1 && prev_ovf==0, i.e. a rising edge; a held-high overflow SHALL produce exactly one event.
REQ-020 The block SHALL detect a threshold event as thresh_en && prev_vld && prev_cnt < thresh && count >= thresh, using an unsigned compare.
REQ-021 The block SHALL NOT detect a threshold event on a downward wrap (prev_cnt > count), unless count >= thresh > prev_cnt holds.
REQ-022 On the first sample after reset (prev_vld==0), the block SHALL detect no threshold event; overflow edge detection SHALL use prev_ovf=0.
REQ-023 When both events occur in the same cycle, the block SHALL push one record with evt_type=11.
REQ-024 The timestamp counter ts SHALL reset to 0, increment every cycle, and wrap modulo 2^TS_W.
REQ-025 Each record SHALL be {type, ts value at the sampling edge, count at the sampling edge}.
REQ-026 Push latency SHALL be 1 cycle: an event sampled at edge N gives evt_valid=1 after edge N if the FIFO was empty; there SHALL be no combinational bypass.
REQ-027 A pop SHALL occur at an edge where evt_valid && evt_ready; evt_* SHALL present the next entry after that edge.
REQ-028 evt_type, evt_ts and evt_count SHALL be stable while evt_valid && !evt_ready.
REQ-029 When the FIFO is full with no pop that cycle, a new event SHALL be discarded and drop_cnt SHALL increment, saturating at 2^DROP_W-1.
REQ-030 When the FIFO is full and a pop occurs in the same cycle, the push SHALL be accepted and level SHALL stay at DEPTH.
REQ-031 With simultaneous push and pop at 0<level<DEPTH, level SHALL be unchanged.
REQ-032 The read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from level.
REQ-033 When evt_valid==0, evt_ready SHALL be ignored.

Reset
REQ-034 With rst_n==0 at an edge, the block SHALL clear ts, level, the pointers, drop_cnt, prev_ovf, prev_cnt and prev_vld to 0.
REQ-035 After a reset edge, evt_valid=0, evt_type=0, evt_ts=0, evt_count=0, level=0 and drop_cnt=0.
REQ-036 During reset, the block SHALL detect no events, including when overflow or count transition.
REQ-037 A reset mid-operation SHALL discard all queued entries immediately; storage contents need not be cleared.

Verification
REQ-038 Reset release, thresh=8, thresh_en=1, count 0,1,...,10 one per cycle, evt_ready=1 -> exactly one record: type=10, evt_count=8, evt_ts=8.
REQ-039 overflow held high for 3 cycles starting at ts=5 -> exactly one record: type=01, evt_ts=5.
REQ-040 count steps 6->8 with thresh=7 in the same cycle overflow rises -> one record: type=11, evt_count=8.
REQ-041 evt_ready=0 with DEPTH=4 and 6 overflow pulses -> level=4, drop_cnt=2, and the first four records pop in order.
REQ-042 FIFO full, evt_ready=1 while a new event arrives -> level stays at 4, drop_cnt unchanged, and the new record is last out.
REQ-043 rst_n=0 for 1 cycle with level=3 -> next cycle evt_valid=0, level=0, drop_cnt=0, ts=0.
